control_logic: RTL and testbench
================================

CONTROL_LOGIC -- requirements
Module: control_logic

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_L, input, 1 bit: asynchronous active-low reset.
REQ-003 SHALL have port data_in, input, 8 bits: opcode bus during fetch.
REQ-004 SHALL have port addr_out, output, 16 bits: address bus.
REQ-005 SHALL have ports INT_L, NMI_L, WAIT_L and BUSREQ_L, each input, 1 bit, active low: interrupt request, non-maskable interrupt, wait request and bus request.
REQ-006 SHALL have ports M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L, BUSACK_L and HALT_L, each output, 1 bit, active low: opcode fetch, memory request, I/O request, read, write, refresh, bus acknowledge and halted.

Function
REQ-007 SHALL sequence states IDLE, T1, T2, TW, T3, T4 and BUSREL, with all outputs registered.
REQ-008 SHALL leave IDLE for T1 on the first rising edge with rst_L high.
REQ-009 SHALL transition T1->T2, T2->T3 (or TW), TW->TW/T3, T3->T4, and T4->T1 (or BUSREL).
REQ-010 SHALL, in T1, T2 and TW: drive addr_out=PC and M1_L=0, MREQ_L=0, RD_L=0, RFSH_L=1.
REQ-011 SHALL, in T3: drive addr_out={8'h00,R}, M1_L=1, RD_L=1, MREQ_L=0, RFSH_L=0.
REQ-012 SHALL, in T4: drive addr_out={8'h00,R}, MREQ_L=1, RFSH_L=0, M1_L=1, RD_L=1.
REQ-013 SHALL latch data_in into IR on the rising edge ending T2 or the last TW.
REQ-014 SHALL increment PC (16-bit, wraps FFFF->0000) on that same edge, unless halted.
REQ-015 SHALL increment R[6:0] (wraps 7F->00; R[7] unchanged) on the edge ending T4.
REQ-016 SHALL hold IORQ_L=1 and WR_L=1 at all times; this block performs only fetch and refresh cycles.
REQ-017 SHALL set a halt flag at the end of T4 when IR==8'h76, driving HALT_L=0 from the next T1.
REQ-018 SHALL, while halted, keep running M1 cycles at the frozen PC, ignore the opcode read, and not increment PC.
REQ-019 SHALL sample INT_L and NMI_L only at the end of T4 while halted, and ignore them otherwise.
REQ-020 SHALL, while halted, clear the halt flag and set HALT_L=1 when either INT_L or NMI_L is low at that sample, resuming normal fetch at the frozen PC.
REQ-021 SHALL sample BUSREQ_L at the end of T4 and enter BUSREL if it is low.
REQ-022 SHALL, in BUSREL: drive BUSACK_L=0, addr_out=16'h0000, and all other strobes high.
REQ-023 SHALL leave BUSREL for T1 on the first edge where BUSREQ_L is high, with PC, R, IR and the halt flag preserved.
REQ-024 SHALL, when BUSREQ_L low coincides with a halt exit at T4, apply the halt exit first and then enter BUSREL.

Reset
REQ-025 SHALL, while rst_L is low, force state=IDLE, PC=0, R=0, IR=0, halt=0, addr_out=0, and all active-low outputs=1.
REQ-026 SHALL abort any cycle in progress when rst_L is asserted mid-cycle, taking effect immediately (asynchronously).

Configuration
REQ-027 SHALL, with macro CTRL_WAIT_EN defined, sample WAIT_L at the end of T2 and of each TW; while WAIT_L is low the next state SHALL be TW, otherwise T3.
REQ-028 SHALL, without CTRL_WAIT_EN, ignore WAIT_L, never enter TW, and always go T2->T3.

Structure
REQ-029 SHALL place the state enum (IDLE, T1, T2, TW, T3, T4, BUSREL) and the constant OP_HALT=8'h76 in a shared package, z80_ctrl_pkg.
REQ-030 SHALL be a single module with no sub-modules.

Verification
REQ-031 SHALL cover: reset release, then one edge to T1; data_in=8'h04 during T2 -> T1/T2 addr_out=0000 with M1_L/MREQ_L/RD_L=0, T3/T4 addr_out=0000 with RFSH_L=0, next T1 addr_out=0001.
REQ-032 SHALL cover: three NOP (8'h00) fetches -> T1 addresses 0000, 0001, 0002 and refresh addresses 0000, 0001, 0002.
REQ-033 SHALL cover: 8'h76 fetched at PC=0 -> HALT_L=0 from the next T1, repeated fetches at 0001; INT_L=0 at T4 -> HALT_L=1, then fetch 0001, then 0002.
REQ-034 SHALL cover, with CTRL_WAIT_EN: WAIT_L=0 for 2 cycles at the end of T2 -> two TW states with strobes held, IR latched from data_in at the end of the last TW.
REQ-035 SHALL cover: BUSREQ_L=0 at T4 -> BUSACK_L=0 and addr_out=0000; release -> T1 resumes at the correct PC.
REQ-036 SHALL cover: rst_L low during T3 -> all outputs inactive immediately; after release, fetch restarts at 0000.

Source files
------------

// File: rtl/z80_ctrl_pkg.sv
// Shared types for the Z80-style fetch/refresh controller: state encoding,
// the HALT opcode and the registered bus image with a helper that builds it.
package z80_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    T1,
    T2,
    TW,
    T3,
    T4,
    BUSREL
  } state_t;

  localparam logic [7:0] OP_HALT = 8'h76;

  typedef struct packed {
    logic [15:0] addr;
    logic        m1_l;
    logic        mreq_l;
    logic        iorq_l;
    logic        rd_l;
    logic        wr_l;
    logic        rfsh_l;
    logic        busack_l;
    logic        halt_l;
  } bus_t;

  // Address parked at zero, every active-low strobe inactive.
  localparam bus_t BUS_QUIET = '{16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  // Bus image for the state about to be entered, so outputs can be registered
  // on the same edge that moves the state.
  function automatic bus_t bus_for(input state_t     st,
                                   input logic [15:0] pc,
                                   input logic [7:0]  r,
                                   input logic        halted);
    bus_t b;
    b = BUS_QUIET;
    case (st)
      T1, T2, TW: begin
        b.addr   = pc;
        b.m1_l   = 1'b0;
        b.mreq_l = 1'b0;
        b.rd_l   = 1'b0;
        b.halt_l = ~halted;
      end
      T3: begin
        b.addr   = {8'h00, r};
        b.mreq_l = 1'b0;
        b.rfsh_l = 1'b0;
        b.halt_l = ~halted;
      end
      T4: begin
        b.addr   = {8'h00, r};
        b.rfsh_l = 1'b0;
        b.halt_l = ~halted;
      end
      BUSREL: b.busack_l = 1'b0;
      default: ;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/control_logic.sv
// Opcode-fetch / refresh sequencer with HALT, interrupt wake-up and bus release.
// Optional wait states are enabled by defining CTRL_WAIT_EN.
module control_logic
  import z80_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_L,
  input  logic [7:0]  data_in,
  input  logic        INT_L,
  input  logic        NMI_L,
  input  logic        WAIT_L,
  input  logic        BUSREQ_L,
  output logic [15:0] addr_out,
  output logic        M1_L,
  output logic        MREQ_L,
  output logic        IORQ_L,
  output logic        RD_L,
  output logic        WR_L,
  output logic        RFSH_L,
  output logic        BUSACK_L,
  output logic        HALT_L
);

  state_t      state, state_n;
  logic [15:0] pc, pc_n;
  logic [7:0]  r, r_n;
  logic [7:0]  ir, ir_n;
  logic        halted, halted_n;
  logic        wait_req;
  bus_t        bus_q;

`ifdef CTRL_WAIT_EN
  assign wait_req = ~WAIT_L;
`else
  logic unused_wait;
  assign unused_wait = WAIT_L;
  assign wait_req    = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal gets a default first so no path infers a latch.
    state_n  = state;
    pc_n     = pc;
    r_n      = r;
    ir_n     = ir;
    halted_n = halted;
    case (state)
      IDLE: state_n = T1;
      T1:   state_n = T2;
      T2, TW: begin
        if (wait_req) begin
          state_n = TW;
        end else begin
          state_n = T3;
          // A halted CPU re-reads the same address and discards the opcode.
          if (!halted) begin
            ir_n = data_in;
            pc_n = pc + 16'd1;
          end
        end
      end
      T3: state_n = T4;
      T4: begin
        r_n = {r[7], r[6:0] + 7'd1};
        if (halted) begin
          if (!INT_L || !NMI_L) halted_n = 1'b0;
        end else if (ir == OP_HALT) begin
          halted_n = 1'b1;
        end
        state_n = BUSREQ_L ? T1 : BUSREL;
      end
      BUSREL: if (BUSREQ_L) state_n = T1;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state  <= IDLE;
      pc     <= 16'h0000;
      r      <= 8'h00;
      ir     <= 8'h00;
      halted <= 1'b0;
      bus_q  <= BUS_QUIET;
    end else begin
      // NOTE: state uses non-blocking assignments so all registers update together.
      state  <= state_n;
      pc     <= pc_n;
      r      <= r_n;
      ir     <= ir_n;
      halted <= halted_n;
      bus_q  <= bus_for(state_n, pc_n, r_n, halted_n);
    end
  end

  assign addr_out = bus_q.addr;
  assign M1_L     = bus_q.m1_l;
  assign MREQ_L   = bus_q.mreq_l;
  assign IORQ_L   = bus_q.iorq_l;
  assign RD_L     = bus_q.rd_l;
  assign WR_L     = bus_q.wr_l;
  assign RFSH_L   = bus_q.rfsh_l;
  assign BUSACK_L = bus_q.busack_l;
  assign HALT_L   = bus_q.halt_l;

endmodule

// File: tb/tb_control_logic.sv
// Self-checking bench for control_logic: directed table plus randomized fetches
// checked against a machine-cycle-level model that expands each fetch into bus cycles.
module tb_control_logic;

  logic        clk = 1'b0;
  logic        rst_L = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic        INT_L = 1'b1, NMI_L = 1'b1, WAIT_L = 1'b1, BUSREQ_L = 1'b1;
  logic [15:0] addr_out;
  logic        M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L, BUSACK_L, HALT_L;

  control_logic dut (
    .clk(clk), .rst_L(rst_L), .data_in(data_in),
    .INT_L(INT_L), .NMI_L(NMI_L), .WAIT_L(WAIT_L), .BUSREQ_L(BUSREQ_L),
    .addr_out(addr_out), .M1_L(M1_L), .MREQ_L(MREQ_L), .IORQ_L(IORQ_L),
    .RD_L(RD_L), .WR_L(WR_L), .RFSH_L(RFSH_L), .BUSACK_L(BUSACK_L), .HALT_L(HALT_L)
  );

  always #5 clk = ~clk;

  // {addr, M1, MREQ, IORQ, RD, WR, RFSH, BUSACK, HALT}
  typedef logic [23:0] bus_img_t;

  typedef struct {
    bit          rst;
    logic [7:0]  op;
    int          wait_n;
    int          busrel_n;
    bit          irq;
    bit          nmi;
    logic [15:0] exp_t1_addr;
    logic        exp_t1_halt_l;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Architectural model state
  logic [15:0] m_pc;
  logic [7:0]  m_r, m_ir;
  bit          m_halted;
  bit          noise = 1'b0;

  function automatic bus_img_t sample();
    return {addr_out, M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L, BUSACK_L, HALT_L};
  endfunction

  function automatic bus_img_t fetch_img(input logic [15:0] pc, input bit h);
    return {pc, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, ~h};
  endfunction

  function automatic bus_img_t refresh_img(input logic [7:0] r, input logic mreq_l, input bit h);
    return {8'h00, r, 1'b1, mreq_l, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, ~h};
  endfunction

  localparam bus_img_t IMG_QUIET  = {16'h0000, 8'hFF};
  localparam bus_img_t IMG_BUSREL = {16'h0000, 8'b1111_1101};

  function automatic logic nz();
    return noise ? 1'($urandom) : 1'b1;
  endfunction

  task automatic check(input string name, input bus_img_t act, input bus_img_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h required %h", name, $time, act, exp);
    end
  endtask

  // Compare the current bus cycle, then set the inputs sampled at its closing edge.
  task automatic step(input string name, input bus_img_t exp, input logic [7:0] d,
                      input logic w, input logic breq, input logic intl, input logic nmil);
    @(negedge clk);
    check(name, sample(), exp);
    data_in  = d;
    WAIT_L   = w;
    BUSREQ_L = breq;
    INT_L    = intl;
    NMI_L    = nmil;
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_r = 8'h00; m_ir = 8'h00; m_halted = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_L = 1'b0;
    data_in = 8'h00; WAIT_L = 1'b1; BUSREQ_L = 1'b1; INT_L = 1'b1; NMI_L = 1'b1;
    #1 check("reset_now", sample(), IMG_QUIET);
    @(negedge clk);
    check("reset_hold", sample(), IMG_QUIET);
    rst_L = 1'b1;
    model_reset();
  endtask

  // One M1 machine cycle: T1, T2, wait states, T3, T4, then any bus release.
  // The opcode is on data_in only in the cycle whose closing edge must latch it.
  task automatic run_fetch(input logic [7:0] op, input int wait_n, input int busrel_n,
                           input bit irq, input bit use_nmi, input bit use_tbl,
                           input logic [15:0] tbl_addr, input logic tbl_halt_l);
    int tw;
    logic [7:0] junk;
    logic       w;
`ifdef CTRL_WAIT_EN
    tw = wait_n;
`else
    tw = 0;
`endif
    junk = (op == 8'h76) ? 8'h00 : 8'h76;
    for (int c = 0; c <= 1 + tw; c++) begin
      w = (c >= 1 && (c - 1) < wait_n) ? 1'b0 : ((c == 0) ? nz() : 1'b1);
      step("fetch", fetch_img(m_pc, m_halted), (c == 1 + tw) ? op : junk,
           w, nz(), nz(), nz());
      if (c == 0 && use_tbl)
        check("tbl_t1", {7'b0, addr_out, HALT_L}, {7'b0, tbl_addr, tbl_halt_l});
    end
    if (!m_halted) begin
      m_ir = op;
      m_pc = m_pc + 16'd1;
    end
    step("refresh_t3", refresh_img(m_r, 1'b0, m_halted), junk, nz(), nz(), nz(), nz());
    step("refresh_t4", refresh_img(m_r, 1'b1, m_halted), junk, nz(),
         (busrel_n > 0) ? 1'b0 : 1'b1,
         (irq && !use_nmi) ? 1'b0 : 1'b1,
         (irq && use_nmi) ? 1'b0 : 1'b1);
    m_r[6:0] = m_r[6:0] + 7'd1;
    if (m_halted) begin
      if (irq) m_halted = 1'b0;
    end else if (m_ir == 8'h76) begin
      m_halted = 1'b1;
    end
    for (int j = 0; j < busrel_n; j++)
      step("busrel", IMG_BUSREL, junk, nz(), (j + 1 < busrel_n) ? 1'b0 : 1'b1, nz(), nz());
  endtask

  vec_t tbl[16];

  initial begin
    //        rst   op     wait rel irq nmi  T1 addr   HALT_L
    tbl[0]  = '{1'b1, 8'h04, 0, 0, 1'b0, 1'b0, 16'h0000, 1'b1};
    tbl[1]  = '{1'b0, 8'h00, 0, 0, 1'b0, 1'b0, 16'h0001, 1'b1};
    tbl[2]  = '{1'b1, 8'h00, 0, 0, 1'b0, 1'b0, 16'h0000, 1'b1};
    tbl[3]  = '{1'b0, 8'h00, 0, 0, 1'b0, 1'b0, 16'h0001, 1'b1};
    tbl[4]  = '{1'b0, 8'h00, 0, 0, 1'b0, 1'b0, 16'h0002, 1'b1};
    tbl[5]  = '{1'b1, 8'h76, 0, 0, 1'b0, 1'b0, 16'h0000, 1'b1};
    tbl[6]  = '{1'b0, 8'h00, 0, 0, 1'b0, 1'b0, 16'h0001, 1'b0};
    tbl[7]  = '{1'b0, 8'h00, 0, 0, 1'b1, 1'b0, 16'h0001, 1'b0};
    tbl[8]  = '{1'b0, 8'h00, 0, 0, 1'b0, 1'b0, 16'h0001, 1'b1};
    tbl[9]  = '{1'b0, 8'h00, 0, 3, 1'b0, 1'b0, 16'h0002, 1'b1};
    tbl[10] = '{1'b0, 8'h00, 0, 0, 1'b0, 1'b0, 16'h0003, 1'b1};
    tbl[11] = '{1'b0, 8'h76, 2, 0, 1'b0, 1'b0, 16'h0004, 1'b1};
    tbl[12] = '{1'b0, 8'h00, 0, 2, 1'b1, 1'b1, 16'h0005, 1'b0};
    tbl[13] = '{1'b0, 8'h00, 1, 0, 1'b0, 1'b0, 16'h0005, 1'b1};
    tbl[14] = '{1'b0, 8'h00, 0, 0, 1'b1, 1'b0, 16'h0006, 1'b1};
    tbl[15] = '{1'b0, 8'h00, 0, 0, 1'b0, 1'b0, 16'h0007, 1'b1};

    model_reset();
    for (int i = 0; i < 16; i++) begin
      if (tbl[i].rst) do_reset();
      run_fetch(tbl[i].op, tbl[i].wait_n, tbl[i].busrel_n, tbl[i].irq, tbl[i].nmi,
                1'b1, tbl[i].exp_t1_addr, tbl[i].exp_t1_halt_l);
    end

    // Asynchronous reset in the middle of T3 must quiet the bus at once.
    do_reset();
    run_fetch(8'h00, 0, 0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
    @(posedge clk); @(posedge clk); @(posedge clk);
    #1 check("mid_t3", sample(), refresh_img(8'h01, 1'b0, 1'b0));
    #1 rst_L = 1'b0;
    #1 check("async_rst", sample(), IMG_QUIET);
    @(negedge clk);
    rst_L = 1'b1;
    model_reset();
    run_fetch(8'h00, 0, 0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1);

    // Randomized fetches with noise on every input outside its sampling point.
    noise = 1'b1;
    do_reset();
    for (int i = 0; i < 220; i++) begin
      logic [7:0] op;
      int wn, bn;
      op = ($urandom_range(0, 5) == 0) ? 8'h76 : 8'($urandom);
      wn = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      bn = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_fetch(op, wn, bn, ($urandom_range(0, 2) == 0), 1'($urandom),
                1'b0, 16'h0000, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
